// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared state encoding and default word width for the stream serializer
//
// Purpose : common definitions imported by stream_serializer and serializer_parity.
// Contents: DEFAULT_WIDTH  - default number of data bits per word
//           state_t        - serializer state encoding (IDLE, SHIFT, PAR)
//           PAR is only ever entered when SERIALIZER_PARITY_EN is defined.
package serializer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;

endpackage

// File: rtl/serializer_parity.sv
// rtl/serializer_parity.sv - even-parity XOR reduction of one parallel word
//
// Purpose : produces the bit that makes the total count of ones (word + bit) even.
// Ports   : data   in  [WIDTH-1:0]  word to reduce
//           parity out 1            XOR of all bits of data
// Only instantiated by stream_serializer when SERIALIZER_PARITY_EN is defined.
module serializer_parity
   import serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] data,
   output logic             parity
);

   assign parity = ^data;

endmodule

// File: rtl/stream_serializer.sv
// rtl/stream_serializer.sv - parallel-to-serial word shifter with valid/ready input handshake
//
// Purpose : accepts a WIDTH-bit word on a valid/ready handshake and drives it one bit
//           per clock on stream_out, optionally followed by an even-parity bit.
// Params  : WIDTH      data bits per word (2..32)
//           LSB_FIRST  0 = MSB first, 1 = LSB first
// Macro   : SERIALIZER_PARITY_EN - when defined, appends one even-parity bit per word
// Ports   : clk        in   clock, rising edge
//           reset      in   asynchronous active-high reset
//           in_data    in   [WIDTH-1:0] word to serialize
//           in_valid   in   in_data holds a word
//           in_ready   out  word accepted this cycle if in_valid (combinational)
//           stream_out out  registered serial bit stream, 0 while idle
//           busy       out  high while a word or its parity bit is on stream_out
//           word_done  out  high during the cycle the final bit of a word is driven
module stream_serializer
   import serializer_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int LSB_FIRST = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             stream_out,
   output logic             busy,
   output logic             word_done
);

   localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`ifndef SERIALIZER_PARITY_EN
   localparam logic [CNT_W-1:0] PENULT_CNT = CNT_W'(WIDTH - 2);
`endif

   state_t           state;
   logic [CNT_W-1:0] bit_cnt;     // index of the data bit currently on stream_out
   logic [WIDTH-1:0] shreg;       // captured word, shifted so the current bit sits at the head
   logic [WIDTH-1:0] shreg_next;
   logic             at_last;
   logic             accept;

   // Head of the shift register is the bit to send next for the chosen bit order.
   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
   endfunction

   assign shreg_next = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
   assign at_last    = (state == SHIFT) && (bit_cnt == LAST_CNT);

`ifdef SERIALIZER_PARITY_EN
   logic par_bit;     // parity of the word in flight, captured at accept
   logic in_parity;

   serializer_parity #(
      .WIDTH (WIDTH)
   ) u_parity (
      .data   (in_data),
      .parity (in_parity)
   );

   // The parity cycle is the last one of a word, so the next word is taken there.
   assign in_ready = !reset && ((state == IDLE) || (state == PAR));
`else
   // Taking the next word during the last data bit keeps the stream gap-free.
   assign in_ready = !reset && ((state == IDLE) || at_last);
`endif

   assign accept = in_valid && in_ready;
   assign busy   = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         stream_out <= 1'b0;
         word_done  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         par_bit    <= 1'b0;
`endif
      end else begin
         word_done <= 1'b0;
         if (accept) begin
            // First bit goes out in the very next cycle; the rest follow from shreg.
            state      <= SHIFT;
            bit_cnt    <= '0;
            shreg      <= in_data;
            stream_out <= head_bit(in_data);
`ifdef SERIALIZER_PARITY_EN
            par_bit    <= in_parity;
`endif
         end else begin
            case (state)
               SHIFT: begin
                  if (bit_cnt != LAST_CNT) begin
                     bit_cnt    <= bit_cnt + 1'b1;
                     shreg      <= shreg_next;
                     stream_out <= head_bit(shreg_next);
`ifndef SERIALIZER_PARITY_EN
                     // Registered, so raise it one cycle ahead of the last data bit.
                     word_done  <= (bit_cnt == PENULT_CNT);
`endif
                  end else begin
`ifdef SERIALIZER_PARITY_EN
                     state      <= PAR;
                     stream_out <= par_bit;
                     word_done  <= 1'b1;
`else
                     state      <= IDLE;
                     stream_out <= 1'b0;
`endif
                  end
               end
`ifdef SERIALIZER_PARITY_EN
               PAR: begin
                  state      <= IDLE;
                  stream_out <= 1'b0;
               end
`endif
               default: begin
                  state      <= IDLE;
                  stream_out <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stream_serializer.sv
// tb/tb_stream_serializer.sv - directed self-checking bench for stream_serializer
module tb_stream_serializer;

   localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int WL = W + PB;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] a_data, b_data;
   logic       a_valid, b_valid;
   logic       a_ready, a_out, a_busy, a_done;
   logic       b_ready, b_out, b_busy, b_done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   stream_serializer #(.WIDTH(8), .LSB_FIRST(0)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (a_data),
      .in_valid   (a_valid),
      .in_ready   (a_ready),
      .stream_out (a_out),
      .busy       (a_busy),
      .word_done  (a_done)
   );

   stream_serializer #(.WIDTH(8), .LSB_FIRST(1)) dut_lsb (
      .clk        (clk),
      .reset      (reset),
      .in_data    (b_data),
      .in_valid   (b_valid),
      .in_ready   (b_ready),
      .stream_out (b_out),
      .busy       (b_busy),
      .word_done  (b_done)
   );

   task automatic test_reset();
      reset   = 1'b1;
      a_valid = 1'b1;
      b_valid = 1'b1;
      a_data  = 8'hFF;
      b_data  = 8'hFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (a_out !== 1'b0)   begin bad++; $display("FAIL reset_out got %b want 0", a_out); end
      total++; if (a_busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got %b want 0", a_busy); end
      total++; if (a_done !== 1'b0)  begin bad++; $display("FAIL reset_done got %b want 0", a_done); end
      total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", a_ready); end
      total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_lsb got %b want 0", b_ready); end
      a_valid = 1'b0;
      b_valid = 1'b0;
      reset   = 1'b0;
      @(negedge clk);
      total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got %b want 1", a_ready); end
      total++; if (a_busy !== 1'b0)  begin bad++; $display("FAIL idle_busy got %b want 0", a_busy); end
   endtask

   // 8'hD0 MSB first: 1,1,0,1,0,0,0,0 then parity 1 (three ones).
   task automatic test_single_msb();
      logic [8:0] exp = 9'b1101_0000_1;
      @(negedge clk);
      a_data  = 8'hD0;
      a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      a_data  = 8'h00;
      for (int i = 0; i < WL; i++) begin
         if (i > 0) @(negedge clk);
         total++; if (a_out !== exp[8-i]) begin bad++; $display("FAIL single_bit%0d got %b want %b", i, a_out, exp[8-i]); end
         total++; if (a_done !== (i == WL-1)) begin bad++; $display("FAIL single_done%0d got %b want %b", i, a_done, (i == WL-1)); end
         total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL single_busy%0d got %b want 1", i, a_busy); end
      end
      @(negedge clk);
      total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got %b want 0", a_busy); end
      total++; if (a_out !== 1'b0)  begin bad++; $display("FAIL single_out_end got %b want 0", a_out); end
      total++; if (a_done !== 1'b0) begin bad++; $display("FAIL single_done_end got %b want 0", a_done); end
   endtask

   // 8'h0B LSB first: 1,1,0,1,0,0,0,0 then parity 1.
   task automatic test_lsb();
      logic [8:0] exp = 9'b1101_0000_1;
      @(negedge clk);
      b_data  = 8'h0B;
      b_valid = 1'b1;
      @(negedge clk);
      b_valid = 1'b0;
      for (int i = 0; i < WL; i++) begin
         if (i > 0) @(negedge clk);
         total++; if (b_out !== exp[8-i]) begin bad++; $display("FAIL lsb_bit%0d got %b want %b", i, b_out, exp[8-i]); end
         total++; if (b_done !== (i == WL-1)) begin bad++; $display("FAIL lsb_done%0d got %b want %b", i, b_done, (i == WL-1)); end
      end
      @(negedge clk);
      total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL lsb_busy_end got %b want 0", b_busy); end
   endtask

   // 8'hD0 then 8'hB4 with in_valid held: contiguous bits, detector sees 11010 twice.
   task automatic test_back_to_back();
      logic [8:0] e0 = 9'b1101_0000_1;
      logic [8:0] e1 = 9'b1011_0100_0;
      logic       e;
      logic [4:0] hist = '0;
      int         seen = 0;
      int         hits = 0;
      @(negedge clk);
      a_data  = 8'hD0;
      a_valid = 1'b1;
      @(negedge clk);
      a_data  = 8'hB4;
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < WL; i++) begin
            if (!(w == 0 && i == 0)) @(negedge clk);
            if (w == 1 && i == 0) a_valid = 1'b0;
            e = (w == 0) ? e0[8-i] : e1[8-i];
            total++; if (a_out !== e) begin bad++; $display("FAIL b2b_w%0d_bit%0d got %b want %b", w, i, a_out, e); end
            total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_w%0d_%0d got %b want 1", w, i, a_busy); end
            if (w == 0) begin
               total++;
               if (a_ready !== (i == WL-1)) begin
                  bad++; $display("FAIL b2b_ready%0d got %b want %b", i, a_ready, (i == WL-1));
               end
            end
            hist = {hist[3:0], a_out};
            seen++;
            if (seen >= 5 && hist == 5'b11010) hits++;
         end
      end
      total++; if (hits != 2) begin bad++; $display("FAIL b2b_detect got %0d want 2", hits); end
      @(negedge clk);
      total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got %b want 0", a_busy); end
   endtask

   // 8'hA5 with in_valid held and in_data changed mid-word; valid dropped before the
   // last-bit edge so no second word starts.
   task automatic test_hold_mid_word();
      logic [8:0] exp = 9'b1010_0101_0;
      @(negedge clk);
      a_data  = 8'hA5;
      a_valid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < WL; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 3) a_data = 8'h3C;
         total++; if (a_out !== exp[8-i]) begin bad++; $display("FAIL hold_bit%0d got %b want %b", i, a_out, exp[8-i]); end
         total++; if (a_ready !== (i == WL-1)) begin bad++; $display("FAIL hold_ready%0d got %b want %b", i, a_ready, (i == WL-1)); end
         if (i == WL-1) a_valid = 1'b0;
      end
      @(negedge clk);
      total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL hold_busy_end got %b want 0", a_busy); end
      total++; if (a_out !== 1'b0)  begin bad++; $display("FAIL hold_out_end got %b want 0", a_out); end
   endtask

   // Abort 8'hFF at bit 4, then 8'h0F must come out cleanly: 0,0,0,0,1,1,1,1, parity 0.
   task automatic test_reset_mid_word();
      logic [8:0] exp = 9'b0000_1111_0;
      @(negedge clk);
      a_data  = 8'hFF;
      a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         total++; if (a_out !== 1'b1) begin bad++; $display("FAIL abort_pre_bit%0d got %b want 1", i, a_out); end
      end
      #2 reset = 1'b1;
      #1;
      total++; if (a_out !== 1'b0)   begin bad++; $display("FAIL abort_out got %b want 0", a_out); end
      total++; if (a_busy !== 1'b0)  begin bad++; $display("FAIL abort_busy got %b want 0", a_busy); end
      total++; if (a_done !== 1'b0)  begin bad++; $display("FAIL abort_done got %b want 0", a_done); end
      total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got %b want 0", a_ready); end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      a_data  = 8'h0F;
      a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      for (int i = 0; i < WL; i++) begin
         if (i > 0) @(negedge clk);
         total++; if (a_out !== exp[8-i]) begin bad++; $display("FAIL fresh_bit%0d got %b want %b", i, a_out, exp[8-i]); end
         total++; if (a_done !== (i == WL-1)) begin bad++; $display("FAIL fresh_done%0d got %b want %b", i, a_done, (i == WL-1)); end
      end
      @(negedge clk);
      total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL fresh_busy_end got %b want 0", a_busy); end
   endtask

   initial begin
      reset   = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      a_data  = 8'h00;
      b_data  = 8'h00;
      test_reset();
      test_single_msb();
      test_lsb();
      test_back_to_back();
      test_hold_mid_word();
      test_reset_mid_word();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
